regfile_sb: RTL and testbench

Parametrised two-read / one-write general-purpose register file with write-through bypass and a per-register pending-write scoreboard, for the pipelined MIPS64 datapath. Decode issues both source reads and marks the destination pending. Writeback clears the pending mark when it commits the result. Register 0 always reads zero and is never pending.

---
 rtl/regfile_sb.sv | 89 ++++++++
 tb/tb_regfile_sb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with write-through bypass and a
// per-register pending-write scoreboard; register 0 is hard-wired to zero.
module regfile_sb #(
  parameter int REG_SZ  = 64,
  parameter int REG_NUM = 32,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ra_re,
  input  logic [IDX_W-1:0]  ra_idx,
  output logic [REG_SZ-1:0] ra_dout,
  output logic              ra_busy,
  input  logic              rb_re,
  input  logic [IDX_W-1:0]  rb_idx,
  output logic [REG_SZ-1:0] rb_dout,
  output logic              rb_busy,
  output logic              r_valid,
  input  logic              we,
  input  logic [IDX_W-1:0]  w_idx,
  input  logic [REG_SZ-1:0] din,
  input  logic              sb_set,
  input  logic [IDX_W-1:0]  sb_idx,
  output logic [CNT_W-1:0]  busy_cnt
);

  logic [REG_SZ-1:0]  mem_r [REG_NUM];
  logic [REG_NUM-1:0] busy_r;
  logic [REG_NUM-1:0] busy_nxt_s;
  logic [CNT_W-1:0]   cnt_s;
  logic               wr_en_s;

  assign wr_en_s = we && (w_idx != {IDX_W{1'b0}});

  // Entry 0 is never written, so the array read already yields zero for it;
  // a same-cycle write to the selected register is forwarded instead.
  function automatic logic [REG_SZ-1:0] rd_data(input logic [IDX_W-1:0] idx);
    if (wr_en_s && (w_idx == idx)) begin
      return din;
    end else begin
      return mem_r[idx];
    end
  endfunction

  // Next scoreboard state (set has priority over clear) and its population count
  always_comb begin
    busy_nxt_s = {REG_NUM{1'b0}};
    cnt_s      = {CNT_W{1'b0}};
    for (int i = 0; i < REG_NUM; i++) begin
      busy_nxt_s[i] = (i != 0) &&
                      ((sb_set && (sb_idx == IDX_W'(i))) ||
                       (busy_r[i] && !(we && (w_idx == IDX_W'(i)))));
      cnt_s = cnt_s + CNT_W'(busy_nxt_s[i]);
    end
  end

  // Array, scoreboard and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem_r[i] <= {REG_SZ{1'b0}};
      end
      busy_r   <= {REG_NUM{1'b0}};
      busy_cnt <= {CNT_W{1'b0}};
      ra_dout  <= {REG_SZ{1'b0}};
      rb_dout  <= {REG_SZ{1'b0}};
      ra_busy  <= 1'b0;
      rb_busy  <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[w_idx] <= din;
      end
      busy_r   <= busy_nxt_s;
      busy_cnt <= cnt_s;
      r_valid  <= ra_re || rb_re;
      if (ra_re) begin
        ra_dout <= rd_data(ra_idx);
        ra_busy <= busy_nxt_s[ra_idx];
      end
      if (rb_re) begin
        rb_dout <= rd_data(rb_idx);
        rb_busy <= busy_nxt_s[rb_idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic, checked
// against an array/flag reference model of the register file.
module tb_regfile_sb;
  localparam int REG_SZ  = 64;
  localparam int REG_NUM = 32;
  localparam int IDX_W   = 5;
  localparam int CNT_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ra_re = 1'b0, rb_re = 1'b0, we = 1'b0, sb_set = 1'b0;
  logic [IDX_W-1:0]  ra_idx = '0, rb_idx = '0, w_idx = '0, sb_idx = '0;
  logic [REG_SZ-1:0] din = '0;
  logic [REG_SZ-1:0] ra_dout, rb_dout;
  logic              ra_busy, rb_busy, r_valid;
  logic [CNT_W-1:0]  busy_cnt;

  always #5 clk = ~clk;

  regfile_sb #(.REG_SZ(REG_SZ), .REG_NUM(REG_NUM), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ra_re(ra_re), .ra_idx(ra_idx), .ra_dout(ra_dout), .ra_busy(ra_busy),
    .rb_re(rb_re), .rb_idx(rb_idx), .rb_dout(rb_dout), .rb_busy(rb_busy),
    .r_valid(r_valid), .we(we), .w_idx(w_idx), .din(din),
    .sb_set(sb_set), .sb_idx(sb_idx), .busy_cnt(busy_cnt)
  );

  // Reference model state and expected outputs
  logic [63:0] m_data [REG_NUM];
  bit          m_busy [REG_NUM];
  logic [63:0] e_ra, e_rb;
  bit          e_rab, e_rbb, e_rv;
  int          e_cnt;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < REG_NUM; i++) begin
      m_data[i] = 64'd0;
      m_busy[i] = 1'b0;
    end
    e_ra = 64'd0; e_rb = 64'd0; e_rab = 1'b0; e_rbb = 1'b0; e_rv = 1'b0; e_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ra_dout"}, ra_dout, e_ra);
    check({tag, ".rb_dout"}, rb_dout, e_rb);
    check({tag, ".ra_busy"}, 64'(ra_busy), 64'(e_rab));
    check({tag, ".rb_busy"}, 64'(rb_busy), 64'(e_rbb));
    check({tag, ".r_valid"}, 64'(r_valid), 64'(e_rv));
    check({tag, ".busy_cnt"}, 64'(busy_cnt), 64'(e_cnt));
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge
  task automatic cyc(input bit a_re, input int a_idx, input bit b_re, input int b_idx,
                     input bit w, input int wi, input logic [63:0] d,
                     input bit s, input int si, input string tag);
    bit bn [REG_NUM];
    ra_re = a_re; ra_idx = IDX_W'(a_idx);
    rb_re = b_re; rb_idx = IDX_W'(b_idx);
    we = w; w_idx = IDX_W'(wi); din = d;
    sb_set = s; sb_idx = IDX_W'(si);
    for (int i = 0; i < REG_NUM; i++)
      bn[i] = (i != 0) && ((s && si == i) || (m_busy[i] && !(w && wi == i)));
    if (a_re) begin
      e_ra  = (a_idx == 0) ? 64'd0 : ((w && wi == a_idx) ? d : m_data[a_idx]);
      e_rab = bn[a_idx];
    end
    if (b_re) begin
      e_rb  = (b_idx == 0) ? 64'd0 : ((w && wi == b_idx) ? d : m_data[b_idx]);
      e_rbb = bn[b_idx];
    end
    e_rv = a_re || b_re;
    if (w && wi != 0) m_data[wi] = d;
    e_cnt = 0;
    for (int i = 0; i < REG_NUM; i++) begin
      m_busy[i] = bn[i];
      e_cnt += int'(bn[i]);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, 64'd0, 1'b0, 0, tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    cyc(1'b1, 1, 1'b1, 31, 1'b0, 0, 64'd0, 1'b0, 0, "rd_after_rst");
    check("rd_after_rst.valid", 64'(r_valid), 64'd1);

    cyc(1'b0, 0, 1'b0, 0, 1'b1, 5, 64'h0123_4567_89AB_CDEF, 1'b0, 0, "wr_r5");
    cyc(1'b1, 5, 1'b0, 0, 1'b0, 0, 64'd0, 1'b0, 0, "rd_r5");
    check("rd_r5.const", ra_dout, 64'h0123_4567_89AB_CDEF);
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, "wr_r0");
    cyc(1'b1, 0, 1'b1, 0, 1'b0, 0, 64'd0, 1'b0, 0, "rd_r0");
    check("rd_r0.const", ra_dout, 64'd0);

    cyc(1'b1, 7, 1'b1, 7, 1'b1, 7, 64'hDEAD, 1'b0, 0, "bypass_r7");
    check("bypass_a.const", ra_dout, 64'hDEAD);
    check("bypass_b.const", rb_dout, 64'hDEAD);
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 9, 64'h99, 1'b0, 0, "wr_r9");
    cyc(1'b0, 0, 1'b1, 9, 1'b1, 8, 64'h1, 1'b0, 0, "no_bypass_r9");
    check("no_bypass.const", rb_dout, 64'h99);

    cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, 64'd0, 1'b1, 3, "set_r3");
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, 64'd0, 1'b1, 4, "set_r4");
    check("cnt2.const", 64'(busy_cnt), 64'd2);
    cyc(1'b1, 3, 1'b0, 0, 1'b0, 0, 64'd0, 1'b0, 0, "rd_r3_busy");
    check("r3_busy.const", 64'(ra_busy), 64'd1);
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 3, 64'h33, 1'b1, 3, "set_wins");
    check("set_wins.const", 64'(busy_cnt), 64'd2);
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 4, 64'h44, 1'b0, 0, "clr_r4");
    check("clr_r4.const", 64'(busy_cnt), 64'd1);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, 64'd0, 1'b1, 0, "set_r0");
    check("set_r0.const", 64'(busy_cnt), 64'd1);

    cyc(1'b1, 10, 1'b0, 0, 1'b0, 0, 64'd0, 1'b1, 10, "set_vis");
    check("set_vis.const", 64'(ra_busy), 64'd1);
    cyc(1'b1, 10, 1'b0, 0, 1'b1, 10, 64'hABC, 1'b0, 0, "clr_vis");
    check("clr_vis.busy", 64'(ra_busy), 64'd0);
    check("clr_vis.dout", ra_dout, 64'hABC);
    idle("idle");
    check("idle.valid", 64'(r_valid), 64'd0);

    // Random traffic, indices biased towards a small range to force collisions
    for (int n = 0; n < 400; n++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? 31 : 7;
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, lim)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, lim)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, lim)),
          {$urandom, $urandom},
          1'($urandom_range(0, 1)), int'($urandom_range(0, lim)), "rand");
    end

    // Reset asserted between edges while a read result is held
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 2, 64'h2222, 1'b1, 6, "pre_rst");
    cyc(1'b1, 2, 1'b1, 6, 1'b0, 0, 64'd0, 1'b0, 0, "inflight");
    ra_re = 1'b0; rb_re = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst");
    #3;
    rst_n = 1'b1;
    cyc(1'b1, 2, 1'b0, 0, 1'b0, 0, 64'd0, 1'b0, 0, "post_rst");
    check("post_rst.dout", ra_dout, 64'd0);
    check("post_rst.cnt", 64'(busy_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
